// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared opcode constants, run-controller states and ASCII decoder
// Contents: OP_* 3-bit opcodes used by both the boolfuck core and bf_run_ctrl,
//           bf_state_e controller states, ascii_to_op() returning {valid, op}.
package bf_pkg;

   localparam logic [2:0] OP_END   = 3'b000;
   localparam logic [2:0] OP_FLIP  = 3'b001;
   localparam logic [2:0] OP_LEFT  = 3'b010;
   localparam logic [2:0] OP_RIGHT = 3'b011;
   localparam logic [2:0] OP_READ  = 3'b100;
   localparam logic [2:0] OP_WRITE = 3'b101;
   localparam logic [2:0] OP_OPEN  = 3'b110;
   localparam logic [2:0] OP_CLOSE = 3'b111;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      FLUSH = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } bf_state_e;

   // Bit 3 flags a real opcode; any other byte is a comment.
   function automatic logic [3:0] ascii_to_op(input logic [7:0] c);
      case (c)
         8'h21:   ascii_to_op = {1'b1, OP_END};   // !
         8'h2B:   ascii_to_op = {1'b1, OP_FLIP};  // +
         8'h3C:   ascii_to_op = {1'b1, OP_LEFT};  // <
         8'h3E:   ascii_to_op = {1'b1, OP_RIGHT}; // >
         8'h2C:   ascii_to_op = {1'b1, OP_READ};  // ,
         8'h3B:   ascii_to_op = {1'b1, OP_WRITE}; // ;
         8'h5B:   ascii_to_op = {1'b1, OP_OPEN};  // [
         8'h5D:   ascii_to_op = {1'b1, OP_CLOSE}; // ]
         default: ascii_to_op = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/bf_bit_packer.sv
// rtl/bf_bit_packer.sv - packs core output bits LSB first into host bytes
// Ports: clk, rst_n (async), clr (sync); bit_valid/bit_data one bit per strobe;
//        flush emits a partial byte zero-padded; out_valid/out_ready/out_data
//        host byte stream; stall = byte held and not taken; empty = no bits buffered.
module bf_bit_packer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       bit_valid,
   input  logic       bit_data,
   input  logic       flush,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       stall,
   output logic       empty
);

   logic [7:0] sh_q;
   logic [7:0] sh_nxt;
   logic [2:0] cnt_q;

   assign stall = out_valid && !out_ready;
   assign empty = (cnt_q == 3'd0);

   // Unwritten positions stay zero, so a flushed partial byte is already padded.
   always_comb begin
      sh_nxt        = sh_q;
      sh_nxt[cnt_q] = bit_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q      <= 8'h00;
         cnt_q     <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else if (clr) begin
         sh_q      <= 8'h00;
         cnt_q     <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         // A completing byte overrides the clear above: host drained the old one this cycle.
         if (bit_valid) begin
            if (cnt_q == 3'd7) begin
               out_data  <= sh_nxt;
               out_valid <= 1'b1;
               sh_q      <= 8'h00;
               cnt_q     <= 3'd0;
            end else begin
               sh_q  <= sh_nxt;
               cnt_q <= cnt_q + 3'd1;
            end
         end else if (flush && !empty && !stall) begin
            out_data  <= sh_q;
            out_valid <= 1'b1;
            sh_q      <= 8'h00;
            cnt_q     <= 3'd0;
         end
      end
   end

endmodule

// File: rtl/bf_run_ctrl.sv
// rtl/bf_run_ctrl.sv - boolfuck sequencer: program load, run control, bit I/O
// Ports: clk, rst_n (async), clear (sync return to IDLE);
//        in_valid/in_ready/in_data host bytes (program text, then run input);
//        out_valid/out_ready/out_data packed output bytes;
//        prg_we/prg_addr/prg_wdata program store writes; core_start run pulse;
//        core_halted, core_rd_req/ack/bit, core_wr_req/bit/ack core bit I/O;
//        prog_len opcode count, state debug view, err sticky load error.
module bf_run_ctrl
   import bf_pkg::*;
#(
   parameter int C = 8,
   parameter int S = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         prg_we,
   output logic [C-1:0] prg_addr,
   output logic [2:0]   prg_wdata,
   output logic         core_start,
   input  logic         core_halted,
   input  logic         core_rd_req,
   output logic         core_rd_ack,
   output logic         core_rd_bit,
   input  logic         core_wr_req,
   input  logic         core_wr_bit,
   output logic         core_wr_ack,
   output logic [C-1:0] prog_len,
   output logic [2:0]   state,
   output logic         err
);

   localparam logic [C-1:0] ADDR_MAX  = {C{1'b1}};
   localparam logic [S-1:0] DEPTH_MAX = {S{1'b1}};
   localparam logic [S-1:0] DEPTH_ONE = S'(1);
   localparam logic [C-1:0] ADDR_ONE  = C'(1);

   bf_state_e    state_q, state_d;
   logic [C-1:0] addr_q;
   logic [S-1:0] depth_q;
   logic [C-1:0] prog_len_q;
   logic [7:0]   in_buf_q;
   logic [3:0]   in_cnt_q;
   logic         rd_ack_q, wr_ack_q;
   logic [3:0]   dec;
   logic         pk_flush, pk_stall, pk_empty;

   assign state    = state_q;
   assign err      = (state_q == ERR);
   assign prg_addr = addr_q;
   assign prog_len = prog_len_q;
   assign core_rd_bit = core_rd_ack & in_buf_q[0];

   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      prg_we      = 1'b0;
      prg_wdata   = 3'b000;
      core_start  = 1'b0;
      core_rd_ack = 1'b0;
      core_wr_ack = 1'b0;
      pk_flush    = 1'b0;
      dec         = ascii_to_op(in_data);
      if (!clear) begin
         case (state_q)
            IDLE: if (in_valid) state_d = LOAD;
            LOAD: begin
               in_ready = 1'b1;
               if (in_valid && dec[3]) begin
                  if (dec[2:0] == OP_END) begin
                     prg_we    = 1'b1;
                     prg_wdata = OP_END;
                     state_d   = (depth_q == '0) ? START : ERR;
                  end else if (dec[2:0] == OP_CLOSE && depth_q == '0) begin
                     state_d = ERR;
                  end else if (dec[2:0] == OP_OPEN && depth_q == DEPTH_MAX) begin
                     state_d = ERR;
                  end else if (addr_q == ADDR_MAX) begin
                     // Last slot is kept for the terminator.
                     state_d = ERR;
                  end else begin
                     prg_we    = 1'b1;
                     prg_wdata = dec[2:0];
                  end
               end
            end
            START: begin
               core_start = 1'b1;
               state_d    = RUN;
            end
            RUN: begin
               in_ready = (in_cnt_q == 4'd0);
               // The *_ack_q terms leave a gap cycle so the core can drop its request.
               core_rd_ack = core_rd_req && (in_cnt_q != 4'd0) && !rd_ack_q;
               core_wr_ack = core_wr_req && !pk_stall && !wr_ack_q;
               if (core_halted) state_d = FLUSH;
            end
            FLUSH: begin
               pk_flush = 1'b1;
               if (pk_empty && !out_valid) state_d = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         depth_q    <= '0;
         prog_len_q <= '0;
         in_buf_q   <= 8'h00;
         in_cnt_q   <= 4'd0;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
      end else if (clear) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         depth_q    <= '0;
         prog_len_q <= '0;
         in_buf_q   <= 8'h00;
         in_cnt_q   <= 4'd0;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ack_q <= core_rd_ack;
         wr_ack_q <= core_wr_ack;
         if (state_q == IDLE && in_valid) begin
            addr_q  <= '0;
            depth_q <= '0;
         end
         if (prg_we) begin
            if (prg_wdata == OP_END) prog_len_q <= addr_q;
            else                     addr_q     <= addr_q + ADDR_ONE;
            if (prg_wdata == OP_OPEN)  depth_q <= depth_q + DEPTH_ONE;
            if (prg_wdata == OP_CLOSE) depth_q <= depth_q - DEPTH_ONE;
         end
         if (state_q == START) begin
            in_buf_q <= 8'h00;
            in_cnt_q <= 4'd0;
         end else if (state_q == RUN && in_valid && in_ready) begin
            in_buf_q <= in_data;
            in_cnt_q <= 4'd8;
         end else if (core_rd_ack) begin
            in_buf_q <= {1'b0, in_buf_q[7:1]};
            in_cnt_q <= in_cnt_q - 4'd1;
         end
      end
   end

   bf_bit_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clear || state_q == START),
      .bit_valid (core_wr_ack),
      .bit_data  (core_wr_bit),
      .flush     (pk_flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .stall     (pk_stall),
      .empty     (pk_empty)
   );

endmodule
